// File: rtl/depar_egress_filter.sv
// Egress filter after the deparser: drops discarded or port-less packets, skid-buffers the rest.
// Optional per-packet statistics counters are enabled by defining EGRESS_STATS_EN.
module depar_egress_filter #(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 512,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_DROP_BIT         = 127,
    parameter int unsigned C_DST_PORT_LSB     = 24
) (
    input  logic                            axis_clk,
    input  logic                            aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
`ifdef EGRESS_STATS_EN
    output logic [31:0]                     stat_fwd_pkts,
    output logic [31:0]                     stat_drop_pkts,
`endif
    input  logic                            m_axis_tready
);

    typedef struct packed {
        logic [C_AXIS_DATA_WIDTH-1:0]   data;
        logic [C_AXIS_DATA_WIDTH/8-1:0] keep;
        logic [C_AXIS_TUSER_WIDTH-1:0]  user;
        logic                           last;
    } beat_t;

    typedef enum logic [1:0] {StIdle, StFwd, StDrop} state_e;

    state_e      state_q, state_d;
    beat_t       mem_q [2];
    beat_t       in_beat;
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  count_q, count_d;
    logic        s_fire, first_drop, push, pop;
    logic        first_keep_fire, first_drop_fire;

    assign s_fire     = s_axis_tvalid && s_axis_tready;
    assign first_drop = s_axis_tuser[C_DROP_BIT] ||
                        (s_axis_tuser[C_DST_PORT_LSB +: 8] == 8'd0);
    assign in_beat    = '{data: s_axis_tdata, keep: s_axis_tkeep,
                          user: s_axis_tuser, last: s_axis_tlast};

    // FSM state register
    always_ff @(posedge axis_clk) begin
        if (!aresetn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (s_fire) begin
            case (state_q)
                StIdle:  if (!s_axis_tlast) state_d = first_drop ? StDrop : StFwd;
                StFwd:   if (s_axis_tlast) state_d = StIdle;
                StDrop:  if (s_axis_tlast) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM outputs; a dropped packet never stalls the sink
    always_comb begin
        s_axis_tready   = aresetn && ((state_q == StDrop) || (count_q != 2'd2));
        first_keep_fire = s_fire && (state_q == StIdle) && !first_drop;
        first_drop_fire = s_fire && (state_q == StIdle) && first_drop;
        push            = first_keep_fire || (s_fire && (state_q == StFwd));
    end

    assign pop = (count_q != 2'd0) && m_axis_tready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= in_beat;
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            count_q  <= count_d;
        end
    end

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = mem_q[rd_ptr_q].data;
    assign m_axis_tkeep  = mem_q[rd_ptr_q].keep;
    assign m_axis_tuser  = mem_q[rd_ptr_q].user;
    assign m_axis_tlast  = mem_q[rd_ptr_q].last;

`ifdef EGRESS_STATS_EN
    logic [31:0] fwd_cnt_q, drop_cnt_q;

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            fwd_cnt_q  <= 32'd0;
            drop_cnt_q <= 32'd0;
        end else begin
            if (first_keep_fire) fwd_cnt_q  <= fwd_cnt_q + 32'd1;
            if (first_drop_fire) drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign stat_fwd_pkts  = fwd_cnt_q;
    assign stat_drop_pkts = drop_cnt_q;
`endif

endmodule

// File: tb/tb_depar_egress_filter.sv
// Bench for depar_egress_filter: packet-level queue model checked every cycle plus directed pins.
// Stats checks are included when EGRESS_STATS_EN is defined.
module tb_depar_egress_filter;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    logic          axis_clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic [UW-1:0] s_axis_tuser;
    logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
`ifdef EGRESS_STATS_EN
    logic [31:0]   stat_fwd_pkts, stat_drop_pkts;
`endif

    depar_egress_filter dut (
        .axis_clk      (axis_clk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
`ifdef EGRESS_STATS_EN
        .stat_fwd_pkts (stat_fwd_pkts),
        .stat_drop_pkts(stat_drop_pkts),
`endif
        .m_axis_tready (m_axis_tready)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Packet-level model: expected buffer contents, whether we are inside a dropped packet.
    beat_t       mdl_q[$];
    bit          mdl_in_pkt = 0, mdl_dropping = 0, mon_en = 0;
    logic [31:0] mdl_fwd = 0, mdl_drop = 0;
    int          in_fires = 0, out_beats = 0;

    always @(negedge axis_clk) begin
        logic  exp_rdy;
        logic  drop;
        beat_t b;
        if (mon_en) begin
            exp_rdy = aresetn && (mdl_dropping || mdl_q.size() < 2);
            chk("s_tready", 640'(s_axis_tready), 640'(exp_rdy));
            chk("m_tvalid", 640'(m_axis_tvalid), 640'(mdl_q.size() != 0));
            if (mdl_q.size() != 0) begin
                chk("m_tdata", 640'(m_axis_tdata), 640'(mdl_q[0].data));
                chk("m_tkeep", 640'(m_axis_tkeep), 640'(mdl_q[0].keep));
                chk("m_tuser", 640'(m_axis_tuser), 640'(mdl_q[0].user));
                chk("m_tlast", 640'(m_axis_tlast), 640'(mdl_q[0].last));
            end
`ifdef EGRESS_STATS_EN
            chk("stat_fwd", 640'(stat_fwd_pkts), 640'(mdl_fwd));
            chk("stat_drop", 640'(stat_drop_pkts), 640'(mdl_drop));
`endif
            // Advance the model to the state after the coming clock edge.
            if (!aresetn) begin
                mdl_q.delete();
                mdl_in_pkt = 0;
                mdl_dropping = 0;
                mdl_fwd = 0;
                mdl_drop = 0;
            end else begin
                if (mdl_q.size() != 0 && m_axis_tready) begin
                    void'(mdl_q.pop_front());
                    out_beats++;
                end
                if (s_axis_tvalid && exp_rdy) begin
                    in_fires++;
                    b = '{data: s_axis_tdata, keep: s_axis_tkeep,
                          user: s_axis_tuser, last: s_axis_tlast};
                    if (!mdl_in_pkt) begin
                        drop = s_axis_tuser[127] || (s_axis_tuser[31:24] == 8'h00);
                        if (drop) mdl_drop++;
                        else      mdl_fwd++;
                        mdl_dropping = drop;
                        mdl_in_pkt = 1;
                    end
                    if (!mdl_dropping) mdl_q.push_back(b);
                    if (s_axis_tlast) begin
                        mdl_in_pkt = 0;
                        mdl_dropping = 0;
                    end
                end
            end
        end
    end

    task automatic wait_accept();
        logic acc;
        int   t = 0;
        do begin
            @(negedge axis_clk);
            acc = s_axis_tready;
            @(posedge axis_clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout: got tready=0 expected 1 within 200 cycles");
        end
    endtask

    task automatic drive_beat(input int b, input int nbeats, input logic [UW-1:0] user,
                              input logic [7:0] seed);
        logic [31:0] word;
        word          = {seed, 8'(b), 16'h5A00 ^ 16'(b * 7)};
        s_axis_tdata  = {16{word}};
        s_axis_tkeep  = (b == nbeats - 1) ? 64'h0000_FFFF_FFFF_FFFF : '1;
        s_axis_tuser  = user ^ {120'd0, 8'(b)};
        s_axis_tlast  = (b == nbeats - 1);
        s_axis_tvalid = 1'b1;
    endtask

    task automatic send_pkt(input int nbeats, input logic [UW-1:0] user, input logic [7:0] seed);
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(b, nbeats, user, seed);
            wait_accept();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge axis_clk);
        #1;
    endtask

    localparam logic [UW-1:0] KEEP_USER  = {96'd0, 8'h04, 24'h000010};
    localparam logic [UW-1:0] DROP_USER  = {1'b1, 95'd0, 8'h02, 24'h000020};
    localparam logic [UW-1:0] NOPRT_USER = {96'd0, 8'h00, 24'h000030};

    int base_out, base_in;

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge axis_clk);
        #1;
        mon_en = 1;
        idle(2);

        // Reset state
        @(negedge axis_clk);
        #2;
        chk("rst_tready", 640'(s_axis_tready), 640'(0));
        chk("rst_tvalid", 640'(m_axis_tvalid), 640'(0));
        chk("rst_tdata", 640'(m_axis_tdata), 640'(0));
        @(posedge axis_clk);
        #1;
        aresetn = 1'b1;
        @(negedge axis_clk);
        #2;
        chk("post_rst_tready", 640'(s_axis_tready), 640'(1));
        @(posedge axis_clk);
        #1;

        // Keep: 3-beat packet to port 2
        base_out = out_beats;
        send_pkt(3, KEEP_USER, 8'h11);
        idle(4);
        chk("keep_out_beats", 640'(out_beats - base_out), 640'(3));
`ifdef EGRESS_STATS_EN
        chk("keep_stat_fwd", 640'(stat_fwd_pkts), 640'(1));
`endif

        // Drop bit: 4-beat packet then a kept 2-beat packet
        base_out = out_beats;
        base_in  = in_fires;
        send_pkt(4, DROP_USER, 8'h22);
        chk("drop_in_beats", 640'(in_fires - base_in), 640'(4));
        send_pkt(2, KEEP_USER, 8'h33);
        idle(4);
        chk("drop_out_beats", 640'(out_beats - base_out), 640'(2));
`ifdef EGRESS_STATS_EN
        chk("drop_stat_drop", 640'(stat_drop_pkts), 640'(1));
`endif

        // No port: single-beat dropped, then back-to-back kept single beat
        base_out = out_beats;
        send_pkt(1, NOPRT_USER, 8'h44);
        send_pkt(1, KEEP_USER, 8'h45);
        idle(4);
        chk("noport_out_beats", 640'(out_beats - base_out), 640'(1));

        // Backpressure: 5-beat kept packet with downstream stalled for 10 cycles
        base_out = out_beats;
        base_in  = in_fires;
        m_axis_tready = 1'b0;
        fork
            send_pkt(5, KEEP_USER, 8'h55);
            begin
                repeat (10) @(negedge axis_clk);
                #2;
                chk("bp_accepted", 640'(in_fires - base_in), 640'(2));
                chk("bp_tready", 640'(s_axis_tready), 640'(0));
                chk("bp_tvalid", 640'(m_axis_tvalid), 640'(1));
                @(posedge axis_clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        idle(5);
        chk("bp_out_beats", 640'(out_beats - base_out), 640'(5));

        // Reset mid-packet during beat 2
        drive_beat(0, 4, KEEP_USER, 8'h66);
        wait_accept();
        drive_beat(1, 4, KEEP_USER, 8'h66);
        aresetn = 1'b0;
        @(posedge axis_clk);
        #1;
        aresetn       = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge axis_clk);
        #2;
        chk("midrst_tvalid", 640'(m_axis_tvalid), 640'(0));
`ifdef EGRESS_STATS_EN
        chk("midrst_stat_fwd", 640'(stat_fwd_pkts), 640'(0));
`endif
        @(posedge axis_clk);
        #1;
        base_out = out_beats;
        send_pkt(2, NOPRT_USER, 8'h77);
        send_pkt(2, KEEP_USER, 8'h78);
        idle(4);
        chk("midrst_out_beats", 640'(out_beats - base_out), 640'(2));

`ifdef EGRESS_STATS_EN
        // Counter wrap
        force dut.fwd_cnt_q = 32'hFFFF_FFFF;
        mdl_fwd = 32'hFFFF_FFFF;
        @(posedge axis_clk);
        #1;
        release dut.fwd_cnt_q;
        send_pkt(1, KEEP_USER, 8'h88);
        idle(3);
        chk("wrap_stat_fwd", 640'(stat_fwd_pkts), 640'(0));
`endif

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
